// File: rtl/ex_mem_elastic_reg.sv
// EX/MEM pipeline register with a valid/ready handshake, a one-entry skid
// buffer and a synchronous flush that turns held entries into bubbles.
module ex_mem_elastic_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned M_W    = 2,
  parameter int unsigned WB_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [ADDR_W-1:0] in_dest_addr,
  input  logic [M_W-1:0]    in_m,
  input  logic [WB_W-1:0]   in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [ADDR_W-1:0] out_dest_addr,
  output logic [M_W-1:0]    out_m,
  output logic [WB_W-1:0]   out_wb
);

  // Main entry (drives the outputs)
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_alu;
  logic [DATA_W-1:0] r_main_rt;
  logic [ADDR_W-1:0] r_main_dest;
  logic [M_W-1:0]    r_main_m;
  logic [WB_W-1:0]   r_main_wb;

  // Skid entry (catches the beat accepted while main is stalled)
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_alu;
  logic [DATA_W-1:0] r_skid_rt;
  logic [ADDR_W-1:0] r_skid_dest;
  logic [M_W-1:0]    r_skid_m;
  logic [WB_W-1:0]   r_skid_wb;

  logic              r_in_ready;

  logic              w_accept;
  logic              w_main_free;

  logic              w_main_valid_nxt;
  logic [DATA_W-1:0] w_main_alu_nxt;
  logic [DATA_W-1:0] w_main_rt_nxt;
  logic [ADDR_W-1:0] w_main_dest_nxt;
  logic [M_W-1:0]    w_main_m_nxt;
  logic [WB_W-1:0]   w_main_wb_nxt;

  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_alu_nxt;
  logic [DATA_W-1:0] w_skid_rt_nxt;
  logic [ADDR_W-1:0] w_skid_dest_nxt;
  logic [M_W-1:0]    w_skid_m_nxt;
  logic [WB_W-1:0]   w_skid_wb_nxt;

  assign w_accept    = in_valid & r_in_ready;
  assign w_main_free = ~r_main_valid | out_ready;

  // Handshake next-state; control fields of an empty entry are kept at zero
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_alu_nxt   = r_main_alu;
    w_main_rt_nxt    = r_main_rt;
    w_main_dest_nxt  = r_main_dest;
    w_main_m_nxt     = r_main_m;
    w_main_wb_nxt    = r_main_wb;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_alu_nxt   = r_skid_alu;
    w_skid_rt_nxt    = r_skid_rt;
    w_skid_dest_nxt  = r_skid_dest;
    w_skid_m_nxt     = r_skid_m;
    w_skid_wb_nxt    = r_skid_wb;

    if (w_main_free) begin
      if (r_skid_valid) begin
        // Older skid beat moves up first so order is preserved
        w_main_valid_nxt = 1'b1;
        w_main_alu_nxt   = r_skid_alu;
        w_main_rt_nxt    = r_skid_rt;
        w_main_dest_nxt  = r_skid_dest;
        w_main_m_nxt     = r_skid_m;
        w_main_wb_nxt    = r_skid_wb;
        w_skid_valid_nxt = 1'b0;
        w_skid_m_nxt     = M_W'(0);
        w_skid_wb_nxt    = WB_W'(0);
      end else if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_main_alu_nxt   = in_alu_result;
        w_main_rt_nxt    = in_rt_data;
        w_main_dest_nxt  = in_dest_addr;
        w_main_m_nxt     = in_m;
        w_main_wb_nxt    = in_wb;
      end else begin
        w_main_valid_nxt = 1'b0;
        w_main_m_nxt     = M_W'(0);
        w_main_wb_nxt    = WB_W'(0);
      end
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_alu_nxt   = in_alu_result;
      w_skid_rt_nxt    = in_rt_data;
      w_skid_dest_nxt  = in_dest_addr;
      w_skid_m_nxt     = in_m;
      w_skid_wb_nxt    = in_wb;
    end
  end

  // State registers: reset beats flush, flush beats the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_alu   <= DATA_W'(0);
      r_main_rt    <= DATA_W'(0);
      r_main_dest  <= ADDR_W'(0);
      r_main_m     <= M_W'(0);
      r_main_wb    <= WB_W'(0);
      r_skid_valid <= 1'b0;
      r_skid_alu   <= DATA_W'(0);
      r_skid_rt    <= DATA_W'(0);
      r_skid_dest  <= ADDR_W'(0);
      r_skid_m     <= M_W'(0);
      r_skid_wb    <= WB_W'(0);
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_m     <= M_W'(0);
      r_main_wb    <= WB_W'(0);
      r_skid_valid <= 1'b0;
      r_skid_m     <= M_W'(0);
      r_skid_wb    <= WB_W'(0);
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_alu   <= w_main_alu_nxt;
      r_main_rt    <= w_main_rt_nxt;
      r_main_dest  <= w_main_dest_nxt;
      r_main_m     <= w_main_m_nxt;
      r_main_wb    <= w_main_wb_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_alu   <= w_skid_alu_nxt;
      r_skid_rt    <= w_skid_rt_nxt;
      r_skid_dest  <= w_skid_dest_nxt;
      r_skid_m     <= w_skid_m_nxt;
      r_skid_wb    <= w_skid_wb_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_valid;
  assign out_alu_result = r_main_alu;
  assign out_rt_data    = r_main_rt;
  assign out_dest_addr  = r_main_dest;
  assign out_m          = r_main_m;
  assign out_wb         = r_main_wb;

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Scoreboard bench for ex_mem_elastic_reg: directed stimulus, accepted beats
// queued as expectations, a negedge monitor checks every delivered beat.
module tb_ex_mem_elastic_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned M_W    = 2;
  localparam int unsigned WB_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic [ADDR_W-1:0] dest;
    logic [M_W-1:0]    m;
    logic [WB_W-1:0]   wb;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_rt_data;
  logic [ADDR_W-1:0] in_dest_addr;
  logic [M_W-1:0]    in_m;
  logic [WB_W-1:0]   in_wb;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_rt_data;
  logic [ADDR_W-1:0] out_dest_addr;
  logic [M_W-1:0]    out_m;
  logic [WB_W-1:0]   out_wb;

  int    n_checks;
  int    n_pass;
  beat_t exp_q[$];
  bit    done;

  ex_mem_elastic_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .M_W(M_W), .WB_W(WB_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_rt_data(in_rt_data),
    .in_dest_addr(in_dest_addr), .in_m(in_m), .in_wb(in_wb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_rt_data(out_rt_data),
    .out_dest_addr(out_dest_addr), .out_m(out_m), .out_wb(out_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Expectation producer: every beat the DUT will accept at the next edge
  always @(negedge clk) begin
    if (!done && !rst && !flush && in_valid && in_ready)
      exp_q.push_back('{alu: in_alu_result, rt: in_rt_data, dest: in_dest_addr,
                        m: in_m, wb: in_wb});
  end

  // Monitor: compare each delivered beat; bubbles must carry zero control
  always @(negedge clk) begin
    beat_t e;
    beat_t a;
    if (!done) begin
      if (rst || flush) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        a = '{alu: out_alu_result, rt: out_rt_data, dest: out_dest_addr,
              m: out_m, wb: out_wb};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got alu=0x%0h dest=%0d expected no beat",
                   out_alu_result, out_dest_addr);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(a), 64'(e));
        end
      end
      if (!out_valid) check("bubble_ctrl", 64'({out_m, out_wb}), 64'd0);
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic v, logic [DATA_W-1:0] alu, logic [ADDR_W-1:0] dest,
                       logic [M_W-1:0] m, logic [WB_W-1:0] wb);
    in_valid      = v;
    in_alu_result = alu;
    in_rt_data    = ~alu;
    in_dest_addr  = dest;
    in_m          = m;
    in_wb         = wb;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    done      = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD, 5'd31, 2'b11, 2'b11);

    // Reset held two cycles with in_valid high
    cyc(2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_m", 64'(out_m), 64'd0);
    check("rst_out_wb", 64'(out_wb), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming: three back-to-back beats, each visible one cycle later
    rst = 1'b0;
    drive(1'b1, 32'h10, 5'd3, 2'b01, 2'b10);
    cyc();
    check("stream0_valid", 64'(out_valid), 64'd1);
    check("stream0_alu", 64'(out_alu_result), 64'h10);
    drive(1'b1, 32'h20, 5'd4, 2'b10, 2'b01);
    cyc();
    check("stream1_alu", 64'(out_alu_result), 64'h20);
    check("stream1_dest", 64'(out_dest_addr), 64'd4);
    drive(1'b1, 32'h30, 5'd5, 2'b00, 2'b11);
    cyc();
    check("stream2_alu", 64'(out_alu_result), 64'h30);
    drive(1'b1, 32'hFFFF_FFFF, 5'd0, 2'b11, 2'b01);
    cyc();
    check("dest0_valid", 64'(out_valid), 64'd1);
    check("dest0_dest", 64'(out_dest_addr), 64'd0);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
    cyc();
    check("stream_end_valid", 64'(out_valid), 64'd0);

    // Backpressure: A held in main, B caught by skid
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd6, 2'b01, 2'b10);
    cyc();
    drive(1'b1, 32'h22, 5'd7, 2'b10, 2'b11);
    cyc();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_hold_alu", 64'(out_alu_result), 64'h11);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
    cyc();
    check("bp_still_hold", 64'(out_alu_result), 64'h11);
    check("bp_hold_m", 64'(out_m), 64'b01);
    out_ready = 1'b1;
    cyc();
    check("bp_b_in_main", 64'(out_alu_result), 64'h22);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    cyc();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush while main and skid both full; C offered alongside the flush
    out_ready = 1'b0;
    drive(1'b1, 32'h44, 5'd8, 2'b01, 2'b01);
    cyc();
    drive(1'b1, 32'h55, 5'd9, 2'b10, 2'b10);
    cyc();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h33, 5'd10, 2'b11, 2'b11);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_m", 64'(out_m), 64'd0);
    check("fl_out_wb", 64'(out_wb), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(3);
    check("fl_no_ghost", 64'(out_valid), 64'd0);

    // Flush with in_ready high: the beat accepted in the flush cycle is lost
    drive(1'b1, 32'h66, 5'd11, 2'b11, 2'b11);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
    check("fl_accept_dropped", 64'(out_valid), 64'd0);
    cyc(2);

    // Bubble gating after delivery of a beat with nonzero control
    drive(1'b1, 32'h77, 5'd12, 2'b01, 2'b11);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
    check("gate_valid", 64'(out_valid), 64'd1);
    check("gate_m_live", 64'(out_m), 64'b01);
    check("gate_wb_live", 64'(out_wb), 64'b11);
    cyc();
    check("gate_bubble_valid", 64'(out_valid), 64'd0);
    check("gate_bubble_m", 64'(out_m), 64'd0);
    check("gate_bubble_wb", 64'(out_wb), 64'd0);

    // Reset while stalled with the skid full
    out_ready = 1'b0;
    drive(1'b1, 32'h88, 5'd13, 2'b10, 2'b10);
    cyc();
    drive(1'b1, 32'h99, 5'd14, 2'b01, 2'b01);
    cyc();
    check("rs_skid_full", 64'(in_ready), 64'd0);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rs_out_valid", 64'(out_valid), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(3);
    check("rs_no_stale", 64'(out_valid), 64'd0);

    // Every accepted, unflushed beat must have been delivered
    @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
